// File: rtl/control_up_down.sv
// control_up_down
//   Command front end for the up/down counter. Two raw push-buttons are
//   synchronised, debounced as a 2-bit code, and arbitrated by a small FSM.
//   The FSM emits one-cycle enable pulses with a registered direction level.
//
//   Optional feature: define CONTROL_UP_DOWN_AUTOREPEAT_EN to build the
//   hold-to-repeat timer. With the macro undefined, a held key yields exactly
//   one pulse and REPEAT_DELAY / REPEAT_PERIOD have no effect.
//
//   Ports
//     clock     in   system clock, rising edge
//     reset     in   asynchronous, active-low reset
//     btn_up    in   raw up key, active-high, asynchronous, may bounce
//     btn_down  in   raw down key, active-high, asynchronous, may bounce
//     enable    out  one-cycle step request to the counter
//     up_down   out  direction to the counter (1 = up, 0 = down)
//     busy      out  high whenever the FSM is not IDLE
module control_up_down #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic enable,
    output logic up_down,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_DOWN = 2'b01;
    localparam logic [1:0] C_UP   = 2'b10;
    localparam logic [1:0] C_BOTH = 2'b11;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("control_up_down: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, FIRE, HOLD, WAIT_REL} state_t;

    // ---------------- synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_up, sync_dn;
    logic [1:0]             code;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_up <= '0;
            sync_dn <= '0;
        end else begin
            sync_up <= {sync_up[SYNC_STAGES-2:0], btn_up};
            sync_dn <= {sync_dn[SYNC_STAGES-2:0], btn_down};
        end
    end

    assign code = {sync_up[SYNC_STAGES-1], sync_dn[SYNC_STAGES-1]};

    // ---------------- debouncer ----------------
    logic [1:0]    code_prev, dcode;
    logic [CW-1:0] db_cnt;

    // db_cnt counts consecutive equal samples beyond the first; once it has
    // reached DEBOUNCE_CYCLES-1 the current matching sample completes the
    // stable run, so dcode is loaded on that same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code_prev <= C_NONE;
            dcode     <= C_NONE;
            db_cnt    <= '0;
        end else begin
            code_prev <= code;
            if (code != code_prev) begin
                db_cnt <= '0;
            end else begin
                if (db_cnt != DB_MAX) db_cnt <= db_cnt + CW'(1);
                if (db_cnt >= DB_LAST) dcode <= code;
            end
        end
    end

    // ---------------- FSM ----------------
    state_t state_q, state_d;
    logic   opposite;

    // A direction other than the one latched at the first pulse.
    assign opposite = up_down ? (dcode == C_DOWN) : (dcode == C_UP);

`ifdef CONTROL_UP_DOWN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX + 1);

    logic [TW-1:0] rpt_timer;
    logic          rpt_again;   // current FIRE was entered from HOLD

    // Loaded during FIRE with N-2: FIRE itself plus the final HOLD cycle at
    // timer==0 make the pulse spacing exactly N cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_timer <= '0;
            rpt_again <= 1'b0;
        end else begin
            if (state_d == FIRE) rpt_again <= (state_q == HOLD);
            if (state_q == FIRE)
                rpt_timer <= rpt_again ? TW'(REPEAT_PERIOD - 2) : TW'(REPEAT_DELAY - 2);
            else if (state_q == HOLD && rpt_timer != '0)
                rpt_timer <= rpt_timer - TW'(1);
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dcode == C_UP || dcode == C_DOWN) state_d = FIRE;
                else if (dcode == C_BOTH)             state_d = WAIT_REL;
            end
            FIRE: state_d = HOLD;
            HOLD: begin
                if (dcode == C_NONE)                   state_d = IDLE;
                else if (dcode == C_BOTH || opposite)  state_d = WAIT_REL;
`ifdef CONTROL_UP_DOWN_AUTOREPEAT_EN
                else if (rpt_timer == '0)              state_d = FIRE;
`endif
            end
            WAIT_REL: if (dcode == C_NONE) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable  <= 1'b0;
            up_down <= 1'b1;
        end else begin
            enable <= (state_d == FIRE);
            // Direction is latched only on a fresh press; repeats keep it.
            if (state_q == IDLE && state_d == FIRE) up_down <= (dcode == C_UP);
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_control_up_down.sv
// Testbench for control_up_down (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8). Stimulus pushes expected pulses
// (absolute edge index and direction) into a queue; a monitor pops and
// compares whenever enable is seen high.
module tb_control_up_down;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic enable, up_down, busy;

    control_up_down #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .enable(enable), .up_down(up_down), .busy(busy)
    );

    always #5 clock = ~clock;

    // Number of rising edges completed so far.
    int edge_n = 0;
    always @(posedge clock) edge_n++;

    typedef struct { int e; bit dir; } pulse_t;
    pulse_t exp_q[$];
    pulse_t mp;

    int  errors = 0;
    int  checks = 0;
    bit  prev_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input int e, input bit dir);
        pulse_t p;
        p.e = e;
        p.dir = dir;
        exp_q.push_back(p);
    endtask

    // Advance to the negedge that follows absolute edge e-1.
    task automatic goto(input int e);
        while (edge_n < e) @(negedge clock);
    endtask

    // Monitor: every enable pulse must match the head of the queue.
    always @(negedge clock) begin
        if (enable) begin
            checks++;
            if (prev_en) begin
                errors++;
                $display("FAIL back_to_back enable at edge %0d", edge_n - 1);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse edge=%0d up_down=%0b", edge_n - 1, up_down);
            end else begin
                mp = exp_q.pop_front();
                if (mp.e != edge_n - 1 || mp.dir != up_down) begin
                    errors++;
                    $display("FAIL pulse actual edge=%0d dir=%0b expected edge=%0d dir=%0b",
                             edge_n - 1, up_down, mp.e, mp.dir);
                end
            end
        end
        prev_en = enable;
    end

    int base;

    initial begin
        // ---- reset held with random buttons ----
        repeat (8) begin
            @(negedge clock);
            chk("rst_enable", enable, 0);
            chk("rst_up_down", up_down, 1);
            chk("rst_busy", busy, 0);
            btn_up   = 1'($urandom);
            btn_down = 1'($urandom);
        end
        @(negedge clock);
        btn_up = 1'b0;
        btn_down = 1'b0;
        reset = 1'b1;
        repeat (12) @(negedge clock);
        chk("idle_busy", busy, 0);

        // ---- clean up press held 36 cycles ----
        base = edge_n;
        btn_up = 1'b1;
        push(base + 7, 1'b1);
`ifdef CONTROL_UP_DOWN_AUTOREPEAT_EN
        push(base + 27, 1'b1);
        push(base + 35, 1'b1);
`endif
        goto(base + 20);
        chk("hold_busy", busy, 1);
        chk("hold_up_down", up_down, 1);
        goto(base + 36);
        btn_up = 1'b0;
        goto(base + 43);
        chk("rel_busy_still", busy, 1);
        goto(base + 44);
        chk("rel_busy_fall", busy, 0);
        chk("t_up_queue", exp_q.size(), 0);

        // ---- bouncing down key, then stable ----
        goto(edge_n + 4);
        base = edge_n;
        for (int i = 0; i < 3; i++) begin
            btn_down = 1'b1;
            goto(base + 4 * i + 2);
            btn_down = 1'b0;
            goto(base + 4 * i + 4);
        end
        btn_down = 1'b1;
        push(base + 19, 1'b0);
        goto(base + 22);
        btn_down = 1'b0;
        goto(base + 29);
        chk("bounce_busy_still", busy, 1);
        goto(base + 30);
        chk("bounce_busy_fall", busy, 0);
        chk("bounce_up_down", up_down, 0);
        chk("bounce_queue", exp_q.size(), 0);

        // ---- both keys together, then clean up press ----
        goto(edge_n + 4);
        base = edge_n;
        btn_up = 1'b1;
        btn_down = 1'b1;
        goto(base + 8);
        chk("both_busy", busy, 1);
        goto(base + 20);
        btn_up = 1'b0;
        btn_down = 1'b0;
        goto(base + 27);
        chk("both_rel_busy_still", busy, 1);
        goto(base + 28);
        chk("both_rel_busy_fall", busy, 0);
        base = edge_n;
        btn_up = 1'b1;
        push(base + 7, 1'b1);
        goto(base + 10);
        btn_up = 1'b0;
        goto(base + 18);
        chk("after_both_busy", busy, 0);
        chk("after_both_up_down", up_down, 1);
        chk("both_queue", exp_q.size(), 0);

        // ---- up held, then down added: no further pulses ----
        goto(edge_n + 4);
        base = edge_n;
        btn_up = 1'b1;
        push(base + 7, 1'b1);
        goto(base + 10);
        btn_down = 1'b1;
        goto(base + 30);
        chk("conflict_up_down", up_down, 1);
        chk("conflict_busy", busy, 1);
        goto(base + 40);
        btn_up = 1'b0;
        btn_down = 1'b0;
        goto(base + 47);
        chk("conflict_busy_still", busy, 1);
        goto(base + 48);
        chk("conflict_busy_fall", busy, 0);
        chk("conflict_queue", exp_q.size(), 0);

        // ---- reset pulse mid-HOLD with up still held ----
        goto(edge_n + 4);
        base = edge_n;
        btn_up = 1'b1;
        push(base + 7, 1'b1);
        goto(base + 12);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_enable", enable, 0);
        chk("async_rst_up_down", up_down, 1);
        @(negedge clock);
        reset = 1'b1;
        base = edge_n;
        push(base + 7, 1'b1);
        goto(base + 12);
        btn_up = 1'b0;
        goto(base + 20);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_queue", exp_q.size(), 0);

        // ---- reset during the enable cycle of a down pulse ----
        goto(edge_n + 4);
        base = edge_n;
        btn_down = 1'b1;
        push(base + 7, 1'b0);
        goto(base + 8);
        chk("fire_enable", enable, 1);
        chk("fire_up_down", up_down, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("fire_rst_enable", enable, 0);
        chk("fire_rst_up_down", up_down, 1);
        chk("fire_rst_busy", busy, 0);
        @(negedge clock);
        btn_down = 1'b0;
        reset = 1'b1;
        repeat (12) @(negedge clock);
        chk("final_busy", busy, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_up_down.md
Name: control_up_down

Overview:
- Front-end command stage that drives the `enable`/`up_down` inputs of the team's parameterised up/down counter.
- Takes two raw push-buttons (up, down). Synchronises, debounces and arbitrates them.
- Emits one-cycle `enable` pulses with a registered direction level.
- Optional hold-to-auto-repeat, so a held key steps the counter at a fixed rate.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per button (>=2).
- DEBOUNCE_CYCLES, 1000, clock cycles a sampled code must stay stable before it is accepted (>=1).
- REPEAT_DELAY, 50000, cycles from first pulse to first repeat pulse (>=2; auto-repeat only).
- REPEAT_PERIOD, 10000, cycles between subsequent repeat pulses (>=2; auto-repeat only).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- btn_up  input  1  raw up key, active-high, asynchronous, may bounce.
- btn_down  input  1  raw down key, active-high, asynchronous, may bounce.
- enable  output  1  one-cycle step request to counter.
- up_down  output  1  direction to counter: 1 = up, 0 = down.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async, reset=0):
  - All synchroniser flops, debounce counter, debounced code and repeat timer cleared.
  - FSM goes to IDLE.
  - Outputs: enable=0, up_down=1, busy=0.
- Synchroniser: each button passes through SYNC_STAGES flops. Synced code = {up_s, down_s}.
- Debouncer:
  - The counter resets to 0 whenever the synced code differs from the previous cycle's synced code; otherwise it increments.
  - When the synced code has been stable for DEBOUNCE_CYCLES consecutive cycles, it is copied to the debounced code `dcode`.
  - Counter saturates; width is ceil(log2(DEBOUNCE_CYCLES+1)).
- dcode decode: 10 = UP, 01 = DOWN, 00 = NONE, 11 = BOTH (illegal).
- FSM states: IDLE, FIRE, HOLD, WAIT_REL.
  - IDLE:
    - dcode UP -> FIRE, up_down<=1.
    - dcode DOWN -> FIRE, up_down<=0.
    - dcode BOTH -> WAIT_REL.
    - dcode NONE -> stay.
  - FIRE: enable=1 for exactly this cycle. Repeat timer loaded (first entry from IDLE: REPEAT_DELAY; re-entry from HOLD: REPEAT_PERIOD). Always -> HOLD.
  - HOLD:
    - dcode NONE -> IDLE.
    - dcode is BOTH or the opposite direction -> WAIT_REL, no pulse.
    - Otherwise the timer counts; on expiry -> FIRE (auto-repeat only).
  - WAIT_REL: stays until dcode NONE, then -> IDLE.
- enable and up_down are registered; both update on the same edge that enters FIRE.
- up_down changes only on entry to FIRE from IDLE; it holds its value at all other times.
- Latency: a clean press ahead of edge 0 produces enable=1 in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (edge 7 with 2/4).
- Repeat spacing: enable pulses at t, t+REPEAT_DELAY, then every REPEAT_PERIOD, exactly, while held.
- Reset mid-operation: outputs return to reset values immediately. If a key is still held after reset release, it is treated as a new press.
- Never more than one enable pulse per FIRE. enable is never high on two consecutive cycles.

Optional Feature:
- Macro: CONTROL_UP_DOWN_AUTOREPEAT_EN.
- Defined: HOLD repeat timer active as described.
- Undefined:
  - Timer logic is not built.
  - HOLD leaves only via dcode change (NONE -> IDLE, other -> WAIT_REL).
  - A held key yields exactly one pulse.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; cycles counted from the stimulus edge):
- Reset: hold reset=0 with random buttons -> enable=0, up_down=1, busy=0 throughout; async clear is seen before the next clock edge.
- Clean btn_up held 36 cycles, macro defined -> enable pulses at cycles 7, 27 and 35 only; up_down=1; busy falls after debounced release.
- btn_down toggles every 2 cycles for 12 cycles, then stays high for 10 cycles; macro undefined -> exactly one pulse, 7 cycles after the last edge; up_down=0.
- btn_up and btn_down high together for 20 cycles, then both low, then btn_up clean press -> no pulse during overlap; FSM passes through WAIT_REL; later press gives one pulse with up_down=1.
- btn_up held (HOLD), then btn_down added -> no further pulses, up_down stays 1 until both are released.
- reset pulsed low for 1 cycle mid-HOLD with btn_up still held -> enable=0 and up_down=1 immediately; a new pulse follows 7 cycles after reset release.
